// File: rtl/pb_gesture_if.sv
// Button gesture bundle: debounced button inputs toward the classifier, event pulses back.
// master = debouncer/application side, slave = classifier.
// Purely combinational wiring; no state.
interface pb_gesture_if;
  logic pb_status;
  logic pb_press;
  logic pb_release;
  logic single_click;
  logic double_click;
  logic long_press;
  logic repeat_pulse;
  logic busy;

  modport master (
    output pb_status, pb_press, pb_release,
    input  single_click, double_click, long_press, repeat_pulse, busy
  );

  modport slave (
    input  pb_status, pb_press, pb_release,
    output single_click, double_click, long_press, repeat_pulse, busy
  );
endinterface

// File: rtl/pb_gesture_classifier.sv
// Classifies debounced button activity into single click, double click and long press pulses.
// Latency: every output is registered; a pulse appears right after the clock edge that decides it.
// No backpressure: events are fire-and-forget pulses. Optional auto-repeat via `define PB_AUTO_REPEAT_EN.
module pb_gesture_classifier #(
  parameter int LONG_CYCLES   = 1000,
  parameter int DCLICK_CYCLES = 300,
  parameter int REPEAT_CYCLES = 100
) (
  input logic         clk,
  input logic         rst,
  pb_gesture_if.slave pb
);

  localparam int MAX_LD  = (LONG_CYCLES > DCLICK_CYCLES) ? LONG_CYCLES : DCLICK_CYCLES;
  localparam int MAX_ALL = (MAX_LD > REPEAT_CYCLES) ? MAX_LD : REPEAT_CYCLES;
  localparam int CW      = $clog2(MAX_ALL + 1);

  localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] DCLICK_LAST = CW'(DCLICK_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX     = '1;
`ifdef PB_AUTO_REPEAT_EN
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    LHOLD  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          single_q, single_d;
  logic          double_q, double_d;
  logic          long_q, long_d;
  logic          repeat_q, repeat_d;
  logic          busy_q, busy_d;
  logic          press_eff;

  // Next-state, counter and event decode; release wins over a coincident press.
  always_comb begin
    press_eff = pb.pb_press & ~pb.pb_release;
    state_d   = state_q;
    cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    single_d  = 1'b0;
    double_d  = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    busy_d    = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (press_eff) state_d = PRESS1;
      end
      PRESS1: begin
        if (pb.pb_release) begin
          state_d = WAIT2;
        end else if (!pb.pb_status) begin
          state_d = IDLE;
        end else if (cnt_q == LONG_LAST) begin
          state_d = LHOLD;
          long_d  = 1'b1;
        end
      end
      WAIT2: begin
        if (press_eff) begin
          state_d = PRESS2;
        end else if (cnt_q == DCLICK_LAST) begin
          state_d  = IDLE;
          single_d = 1'b1;
        end
      end
      PRESS2: begin
        if (pb.pb_release) begin
          state_d  = IDLE;
          double_d = 1'b1;
        end else if (!pb.pb_status) begin
          state_d = IDLE;
        end
      end
      LHOLD: begin
        if (pb.pb_release || !pb.pb_status) begin
          state_d = IDLE;
        end
`ifdef PB_AUTO_REPEAT_EN
        else if (cnt_q == REPEAT_LAST) begin
          cnt_d    = '0;
          repeat_d = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    // Idle holds the counter at zero; any state change restarts timing.
    if (state_d != state_q || state_q == IDLE) cnt_d = '0;
  end

  // State, counter and registered outputs; synchronous reset aborts any gesture silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      single_q <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      single_q <= single_d;
      double_q <= double_d;
      long_q   <= long_d;
      repeat_q <= repeat_d;
      busy_q   <= busy_d;
    end
  end

  assign pb.single_click = single_q;
  assign pb.double_click = double_q;
  assign pb.long_press   = long_q;
  assign pb.repeat_pulse = repeat_q;
  assign pb.busy         = busy_q;

endmodule

// File: tb/tb_pb_gesture_classifier.sv
// Directed bench for pb_gesture_classifier with LONG=20, DCLICK=10, REPEAT=5.
// Each scenario is described by event times relative to the press edge t=0;
// outputs {single,double,long,repeat,busy} are compared after every edge.
module tb_pb_gesture_classifier;
  localparam int L = 20;
  localparam int D = 10;
  localparam int R = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pb_gesture_if pbif();

  pb_gesture_classifier #(
    .LONG_CYCLES  (L),
    .DCLICK_CYCLES(D),
    .REPEAT_CYCLES(R)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pb (pbif.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // -1 in any time field means "never".
  typedef struct {
    string name;
    int p1, r1, p2, r2, drop, rst_at, len;
    int es, ed, el, idle_at;
  } scen_t;

  scen_t sc[10];

  function automatic logic [4:0] outs();
    return {pbif.single_click, pbif.double_click, pbif.long_press, pbif.repeat_pulse, pbif.busy};
  endfunction

  task automatic check(input string name, input int t, input logic [4:0] got, input logic [4:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d {sgl,dbl,lng,rep,busy} got=%b want=%b", name, t, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pbif.pb_status  = 1'b0;
    pbif.pb_press   = 1'b0;
    pbif.pb_release = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", -1, outs(), 5'b0);
    rst = 1'b0;
  endtask

  task automatic run_scen(input scen_t s);
    logic [4:0] exp;
    logic rep;
    for (int t = 0; t < s.len; t++) begin
      pbif.pb_press   = (t == s.p1) || (t == s.p2);
      pbif.pb_release = (t == s.r1) || (t == s.r2);
      pbif.pb_status  = (t >= s.p1 && (s.r1 < 0 || t < s.r1) && (s.drop < 0 || t < s.drop)) ||
                        (s.p2 >= 0 && t >= s.p2 && (s.r2 < 0 || t < s.r2));
      rst = (t == s.rst_at);
      @(posedge clk);
      #1;
      rep = 1'b0;
`ifdef PB_AUTO_REPEAT_EN
      rep = (s.el >= 0) && (t > s.el) && ((t - s.el) % R == 0) && (t < s.r1);
`endif
      exp = {t == s.es, t == s.ed, t == s.el, rep, (t >= s.p1 + 1) && (t <= s.idle_at)};
      check(s.name, t, outs(), exp);
    end
    rst = 1'b0;
  endtask

  initial begin
    //            name            p1 r1  p2  r2 drop rst len  es  ed  el idle
    sc[0] = '{"single_click",     0,  5, -1, -1, -1, -1, 20, 15, -1, -1, 15};
    sc[1] = '{"double_click",     0,  4, 10, 13, -1, -1, 25, -1, 13, -1, 13};
    sc[2] = '{"long_hold",        0, 40, -1, -1, -1, -1, 50, -1, -1, 20, 40};
    sc[3] = '{"release_at_thr",   0, 20, -1, -1, -1, -1, 35, 30, -1, -1, 30};
    sc[4] = '{"reset_abort",      0,  6, -1, -1, -1,  3, 12, -1, -1, -1,  2};
    sc[5] = '{"status_glitch",    0, -1, -1, -1,  3, -1, 10, -1, -1, -1,  3};
    sc[6] = '{"release_thr_m1",   0, 19, -1, -1, -1, -1, 35, 29, -1, -1, 29};
    sc[7] = '{"long_second",      0,  2,  5, 40, -1, -1, 45, -1, 40, -1, 40};
    sc[8] = '{"press_at_timeout", 0,  3, 13, 15, -1, -1, 20, -1, 15, -1, 15};
    sc[9] = '{"press_and_rel",    0,  0, -1, -1, -1, -1, 15, -1, -1, -1, -1};

    for (int i = 0; i < 10; i++) begin
      do_reset();
      run_scen(sc[i]);
    end

    // A second press pulse while already held must not restart or alter the gesture.
    do_reset();
    for (int t = 0; t < 25; t++) begin
      pbif.pb_press   = (t == 0) || (t == 5);
      pbif.pb_release = (t == 8);
      pbif.pb_status  = (t < 8);
      @(posedge clk);
      #1;
      check("repress_ignored", t, outs(), {t == 18, 1'b0, 1'b0, 1'b0, (t >= 1) && (t <= 18)});
    end

    // Reset held while the button is pressed: nothing may start.
    rst = 1'b1;
    for (int t = 0; t < 4; t++) begin
      pbif.pb_press   = (t == 1);
      pbif.pb_release = 1'b0;
      pbif.pb_status  = 1'b1;
      @(posedge clk);
      #1;
      check("press_in_reset", t, outs(), 5'b0);
    end
    rst = 1'b0;
    pbif.pb_status = 1'b0;
    @(posedge clk);
    #1;
    check("after_reset_idle", 0, outs(), 5'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
